// File: rtl/q_frame_accum_pkg.sv
// Shared widths and FSM encoding for the q1/q2/q3 frame accumulator.
package q_frame_accum_pkg;
  localparam int SUM_W_DEF  = 18;
  localparam int CNT_W_DEF  = 8;
  localparam int LANE_W_DEF = 3;
  localparam int BEAT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/q_lane_sum3.sv
// Combinational sum of the three unsigned input lanes of one beat.
module q_lane_sum3
  import q_frame_accum_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [LANE_W-1:0] i_q1,
  input  logic [LANE_W-1:0] i_q2,
  input  logic [LANE_W-1:0] i_q3,
  output logic [BEAT_W-1:0] o_sum
);
  assign o_sum = BEAT_W'(i_q1) + BEAT_W'(i_q2) + BEAT_W'(i_q3);
endmodule

// File: rtl/q_frame_accum.sv
// Frame accumulator: sums per-beat lane totals over sof..eof and holds the result.
// Build option Q_FRAME_ACCUM_SAT_EN clamps the total instead of wrapping it.
module q_frame_accum
  import q_frame_accum_pkg::*;
#(
  parameter int SUM_W  = SUM_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic              in_eof,
  input  logic [LANE_W-1:0] q1,
  input  logic [LANE_W-1:0] q2,
  input  logic [LANE_W-1:0] q3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf,
  output logic              err_drop,
  output logic              err_restart
);
  state_t             r_state, w_state_nxt;
  logic [SUM_W-1:0]   r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic [SUM_W-1:0]   r_out_sum;
  logic [CNT_W-1:0]   r_out_cnt;
  logic               r_out_ovf;
  logic               r_err_drop, r_err_restart;
  logic               w_drop, w_restart, w_accept, w_load_out;
  logic [BEAT_W-1:0]  w_beat;
  logic [SUM_W:0]     w_add;

  q_lane_sum3 #(.LANE_W(LANE_W)) u_sum (
    .i_q1 (q1),
    .i_q2 (q2),
    .i_q3 (q3),
    .o_sum(w_beat)
  );

  assign in_ready = !reset && (r_state != ST_HOLD);
  assign w_accept = in_valid && in_ready;
  // Extra top bit captures the carry-out used for overflow detection.
  assign w_add    = {1'b0, r_acc} + (SUM_W+1)'(w_beat);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_drop      = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (in_sof) begin
            w_acc_nxt   = SUM_W'(w_beat);
            w_cnt_nxt   = CNT_W'(1);
            w_ovf_nxt   = 1'b0;
            w_state_nxt = in_eof ? ST_HOLD : ST_ACCUM;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          if (in_sof) begin
            w_acc_nxt   = SUM_W'(w_beat);
            w_cnt_nxt   = CNT_W'(1);
            w_ovf_nxt   = 1'b0;
            w_restart   = 1'b1;
            w_state_nxt = in_eof ? ST_HOLD : ST_ACCUM;
          end else begin
`ifdef Q_FRAME_ACCUM_SAT_EN
            // Once clamped every later add carries again, so acc stays pinned.
            if (w_add[SUM_W]) begin
              w_acc_nxt = {SUM_W{1'b1}};
              w_ovf_nxt = 1'b1;
            end else begin
              w_acc_nxt = w_add[SUM_W-1:0];
            end
`else
            w_acc_nxt = w_add[SUM_W-1:0];
            w_ovf_nxt = r_ovf | w_add[SUM_W];
`endif
            if (r_cnt != {CNT_W{1'b1}}) w_cnt_nxt = r_cnt + CNT_W'(1);
            if (in_eof) w_state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_load_out = (r_state != ST_HOLD) && (w_state_nxt == ST_HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc         <= '0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_out_sum     <= '0;
      r_out_cnt     <= '0;
      r_out_ovf     <= 1'b0;
      r_err_drop    <= 1'b0;
      r_err_restart <= 1'b0;
    end else begin
      r_acc         <= w_acc_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ovf         <= w_ovf_nxt;
      r_err_drop    <= w_drop;
      r_err_restart <= w_restart;
      // Result registers persist after HOLD until the next frame replaces them.
      if (w_load_out) begin
        r_out_sum <= w_acc_nxt;
        r_out_cnt <= w_cnt_nxt;
        r_out_ovf <= w_ovf_nxt;
      end
    end
  end

  assign out_valid   = (r_state == ST_HOLD);
  assign out_sum     = r_out_sum;
  assign out_count   = r_out_cnt;
  assign out_ovf     = r_out_ovf;
  assign err_drop    = r_err_drop;
  assign err_restart = r_err_restart;
endmodule

// File: tb/tb_q_frame_accum.sv
// Directed table-driven bench for q_frame_accum plus multi-cycle corner sequences.
module tb_q_frame_accum;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_sof, in_eof;
  logic [2:0]  q1, q2, q3;
  logic        out_valid, out_ready;
  logic [17:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf, err_drop, err_restart;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  q_frame_accum dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_eof(in_eof), .q1(q1), .q2(q2), .q3(q3),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf), .err_drop(err_drop),
    .err_restart(err_restart)
  );

  typedef struct {
    logic v, sof, eof;
    logic [2:0] a, b, c;
    logic ordy;
    logic e_rdy, e_ov;
    int   e_sum, e_cnt;
    logic e_ovf, e_drop, e_rst;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(logic v, logic sof, logic eof, logic [2:0] a, logic [2:0] b,
                              logic [2:0] c, logic ordy, logic e_rdy, logic e_ov,
                              int e_sum, int e_cnt, logic e_ovf, logic e_drop, logic e_rst);
    vec_t t;
    t.v = v; t.sof = sof; t.eof = eof; t.a = a; t.b = b; t.c = c; t.ordy = ordy;
    t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_sum = e_sum; t.e_cnt = e_cnt;
    t.e_ovf = e_ovf; t.e_drop = e_drop; t.e_rst = e_rst;
    return t;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic rdy, logic ov, int sum, int cnt,
                         logic ovf, logic drop, logic rst);
    chk({tag, ".in_ready"},    int'(in_ready),    int'(rdy));
    chk({tag, ".out_valid"},   int'(out_valid),   int'(ov));
    chk({tag, ".out_sum"},     int'(out_sum),     sum);
    chk({tag, ".out_count"},   int'(out_count),   cnt);
    chk({tag, ".out_ovf"},     int'(out_ovf),     int'(ovf));
    chk({tag, ".err_drop"},    int'(err_drop),    int'(drop));
    chk({tag, ".err_restart"}, int'(err_restart), int'(rst));
  endtask

  task automatic drive(logic v, logic sof, logic eof, logic [2:0] a, logic [2:0] b,
                       logic [2:0] c, logic ordy);
    in_valid = v; in_sof = sof; in_eof = eof; q1 = a; q2 = b; q3 = c; out_ready = ordy;
  endtask

  initial begin
    int exp_ovf_sum;
`ifdef Q_FRAME_ACCUM_SAT_EN
    exp_ovf_sum = 262143;
`else
    exp_ovf_sum = 20;
`endif
    // Expectations describe outputs seen before the row's own clock edge.
    //               v sof eof  a  b  c ordy  rdy ov sum cnt ovf drp rst
    tbl[0]  = mk(1, 1, 0, 1, 2, 3, 1,  1, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 7, 7, 7, 1,  1, 0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 1, 0, 0, 1, 1,  1, 0,  0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 28, 3, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 3, 3, 3, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 28, 3, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[8]  = mk(1, 1, 0, 1, 1, 1, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 1, 1, 1, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 1, 1, 1, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 1, 1, 1, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 2, 0, 0, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 0, 3, 0, 1,  1, 0, 28, 3, 0, 0, 1);
    tbl[14] = mk(1, 0, 1, 0, 0, 4, 1,  1, 0, 28, 3, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1,  0, 1,  9, 3, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0,  9, 3, 0, 0, 0);
    tbl[17] = mk(1, 1, 1, 2, 2, 2, 0,  1, 0,  9, 3, 0, 0, 0);
    tbl[18] = mk(1, 0, 0, 5, 5, 5, 0,  0, 1,  6, 1, 0, 0, 0);
    tbl[19] = mk(1, 1, 0, 5, 5, 5, 0,  0, 1,  6, 1, 0, 0, 0);
    tbl[20] = mk(1, 0, 1, 5, 5, 5, 0,  0, 1,  6, 1, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 5, 5, 5, 0,  0, 1,  6, 1, 0, 0, 0);
    tbl[22] = mk(1, 0, 0, 5, 5, 5, 0,  0, 1,  6, 1, 0, 0, 0);
    tbl[23] = mk(1, 0, 0, 5, 5, 5, 1,  0, 1,  6, 1, 0, 0, 0);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0,  1, 0,  6, 1, 0, 0, 0);

    reset = 1'b1;
    drive(1, 1, 0, 7, 7, 7, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all($sformatf("reset%0d", i), 0, 0, 0, 0, 0, 0, 0);
    end

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].v, tbl[i].sof, tbl[i].eof, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].ordy);
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_sum,
              tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_drop, tbl[i].e_rst);
      @(negedge clk);
    end

    // Overflow frame: 12484 beats of 21.
    for (int i = 0; i < 12484; i++) begin
      drive(1, i == 0, i == 12483, 7, 7, 7, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_all("ovf_hold", 0, 1, exp_ovf_sum, 255, 1, 0, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk_all("ovf_idle", 1, 0, exp_ovf_sum, 255, 1, 0, 0);

    // Reset in the middle of a frame leaves no residue.
    @(negedge clk);
    drive(1, 1, 0, 1, 1, 1, 0);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drive(1, 1, 1, 1, 0, 0, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk_all("postrst", 0, 1, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk_all("postrst_idle", 1, 0, 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
